// File: rtl/i2c_mem_slave_pkg.sv
// Shared definitions for the I2C memory slave: FSM states, bus constants and default geometry.
package i2c_mem_slave_pkg;

  localparam int unsigned DATAWIDTH        = 8;
  localparam int unsigned ADDRWIDTH        = 4;
  localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h50;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_MEM_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, optional majority glitch filter (I2C_SLV_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection on the resynchronized lines.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_s;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Reset to the idle-bus level so leaving reset creates no false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // 2-of-3 vote over the current and two previous samples drops single-clock pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave that turns bus frames into memory write strobes and read fetches.
// Build option: define I2C_SLV_GLITCH_FILTER_EN to add the SCL/SDA majority filter.
module i2c_mem_slave #(
  parameter int unsigned DATAWIDTH = i2c_mem_slave_pkg::DATAWIDTH,
  parameter int unsigned ADDRWIDTH = i2c_mem_slave_pkg::ADDRWIDTH,
  parameter logic [6:0]  DEV_ADDR  = i2c_mem_slave_pkg::DEV_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 mem_wr_en_in,
  output logic [ADDRWIDTH-1:0] mem_addr_in,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_rd_data,
  output logic                 busy
);
  import i2c_mem_slave_pkg::*;

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_slv_state_t       state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rw_q, rw_d;
  logic                 mack_q, mack_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 load_rd;
  logic [7:0]           byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  // bit_cnt counts sampled bits; 8 means the byte is complete and the ACK slot is next.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    addr_d    = wr_en_q ? ADDRWIDTH'(addr_q + 1'b1) : addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    load_rd   = 1'b0;

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = S_DEV_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = byte_in;
            bit_cnt_d = 4'(bit_cnt_q + 4'd1);
            if (bit_cnt_q == 4'd7 && state_q == S_MEM_ADDR) addr_d = ADDRWIDTH'(byte_in);
            if (bit_cnt_q == 4'd7 && state_q == S_WR_DATA) begin
              wr_en_d = 1'b1;
              data_d  = DATAWIDTH'(byte_in);
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            if (state_q == S_MEM_ADDR) state_d = S_ADDR_ACK;
            else if (state_q == S_WR_DATA) state_d = S_WR_ACK;
            else if (shift_q[7:1] == DEV_ADDR) begin
              state_d = S_DEV_ACK;
              rw_d    = shift_q[0];
            end else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_DEV_ACK, S_ADDR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == S_DEV_ACK && rw_q) load_rd = 1'b1;
            else if (state_q == S_DEV_ACK) state_d = S_MEM_ADDR;
            else state_d = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = 4'(bit_cnt_q + 4'd1);
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = S_RD_ACK;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        S_RD_ACK: begin
          if (scl_rise) mack_d = sda_s;
          else if (scl_fall) begin
            if (mack_q == I2C_ACK) load_rd = 1'b1;
            else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase

      // Fetch the next read byte and present its MSB on the same edge that ends the ACK slot.
      if (load_rd) begin
        state_d  = S_RD_DATA;
        shift_d  = 8'(mem_rd_data);
        sda_oe_d = ~mem_rd_data[DATAWIDTH-1];
        addr_d   = ADDRWIDTH'(addr_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      mack_q    <= I2C_NACK;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe       = sda_oe_q;
  assign mem_wr_en_in = wr_en_q;
  assign mem_addr_in  = addr_q;
  assign mem_data_in  = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: a bus-level I2C master, a memory array fed by the write strobes,
// and a reference memory image updated from transaction contents.
module tb_i2c_mem_slave;
  import i2c_mem_slave_pkg::*;

  localparam int unsigned AW    = ADDRWIDTH;
  localparam int          DEPTH = 1 << AW;
  localparam int          Q     = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          sda_oe, mem_wr_en_in, busy;
  logic [AW-1:0] mem_addr_in;
  logic [7:0]    mem_data_in, mem_rd_data;

  logic [7:0]    mem     [DEPTH];
  logic [7:0]    ref_mem [DEPTH];
  logic [AW-1:0] st_a [$];
  logic [7:0]    st_d [$];
  int            total = 0;
  int            bad = 0;

  assign sda_line    = sda_m & ~sda_oe;
  assign mem_rd_data = mem[mem_addr_in];

  always #5 clk = ~clk;

  i2c_mem_slave dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .mem_wr_en_in (mem_wr_en_in),
    .mem_addr_in  (mem_addr_in),
    .mem_data_in  (mem_data_in),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy)
  );

  // The memory array: captures every strobe and logs it for the checks.
  always @(negedge clk) begin
    if (mem_wr_en_in) begin
      mem[mem_addr_in] = mem_data_in;
      st_a.push_back(mem_addr_in);
      st_d.push_back(mem_data_in);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    acked = ~sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl_m = 1'b1; tick(Q);
      b[i] = sda_line;
      tick(Q);
      scl_m = 1'b0;
    end
    tick(Q);
    sda_m = ~master_ack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  // Write frame; the reference image is updated only when the slave is expected to accept.
  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] addr,
                        input logic [7:0] d [16], input int n, input logic exp_ack);
    logic a;
    int   base;
    base = st_a.size();
    bus_start();
    write_byte(dev, a);  check("dev_ack", 32'(a), 32'(exp_ack));
    write_byte(addr, a); check("addr_ack", 32'(a), 32'(exp_ack));
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], a); check("data_ack", 32'(a), 32'(exp_ack));
      if (exp_ack) ref_mem[(int'(addr) + i) % DEPTH] = d[i];
    end
    check("busy_in_frame", 32'(busy), 32'd1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("strobe_count", 32'(st_a.size() - base), exp_ack ? 32'(n) : 32'd0);
    for (int k = 0; k < n && base + k < st_a.size(); k++) begin
      check("strobe_addr", 32'(st_a[base + k]), 32'((int'(addr) + k) % DEPTH));
      check("strobe_data", 32'(st_d[base + k]), 32'(d[k]));
    end
    if (exp_ack) check("ptr_after_write", 32'(mem_addr_in), 32'((int'(addr) + n) % DEPTH));
  endtask

  // Combined read: address write, repeated START, n bytes with the master NACKing the last.
  task automatic rd_txn(input logic [7:0] addr, input int n);
    logic       a;
    logic [7:0] b;
    bus_start();
    write_byte(8'hA0, a); check("rd_dev_w_ack", 32'(a), 32'd1);
    write_byte(addr, a);  check("rd_addr_ack", 32'(a), 32'd1);
    bus_start();
    write_byte(8'hA1, a); check("rd_dev_r_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i != n - 1);
      check("rd_data", 32'(b), 32'(ref_mem[(int'(addr) + i) % DEPTH]));
    end
    tick(2);
    check("oe_after_nack", 32'(sda_oe), 32'd0);
    check("busy_after_nack", 32'(busy), 32'd1);
    bus_stop();
    check("rd_busy_after_stop", 32'(busy), 32'd0);
    check("ptr_after_read", 32'(mem_addr_in), 32'((int'(addr) + n) % DEPTH));
  endtask

  typedef struct {
    logic [7:0]    dev;
    logic [7:0]    addr;
    logic [7:0]    data;
    logic          exp_ack;
    int            exp_n;
    logic [AW-1:0] exp_a;
    logic [7:0]    exp_d;
  } vec_t;

  initial begin
    vec_t       vecs [5];
    logic [7:0] d [16];
    logic       a;
    logic       seen;
    logic [7:0] ra;
    int         n, base;

    vecs[0] = '{8'hA0, 8'h03, 8'h5A, 1'b1, 1, 4'h3, 8'h5A};
    vecs[1] = '{8'hA0, 8'h0C, 8'hE7, 1'b1, 1, 4'hC, 8'hE7};
    vecs[2] = '{8'hA2, 8'h03, 8'h11, 1'b0, 0, 4'h0, 8'h00};
    vecs[3] = '{8'hA0, 8'hF5, 8'h96, 1'b1, 1, 4'h5, 8'h96};
    vecs[4] = '{8'hB0, 8'h01, 8'h77, 1'b0, 0, 4'h0, 8'h00};
    for (int i = 0; i < 16; i++) d[i] = 8'h00;

    tick(1);
    reset_n = 1'b0;
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en_in), 32'd0);
    check("rst_addr", 32'(mem_addr_in), 32'd0);
    check("rst_data", 32'(mem_data_in), 32'd0);
    reset_n = 1'b1;
    tick(4);

    // One-clock SDA low pulse with SCL high.
    seen = 1'b0;
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | busy;
    end
`ifdef I2C_SLV_GLITCH_FILTER_EN
    check("glitch_start", 32'(seen), 32'd0);
`else
    check("glitch_start", 32'(seen), 32'd1);
`endif
    check("glitch_idle", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      base = st_a.size();
      d[0] = vecs[v].data;
      wr_txn(vecs[v].dev, vecs[v].addr, d, 1, vecs[v].exp_ack);
      check("vec_strobes", 32'(st_a.size() - base), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n == 1 && st_a.size() > base) begin
        check("vec_addr", 32'(st_a[base]), 32'(vecs[v].exp_a));
        check("vec_data", 32'(st_d[base]), 32'(vecs[v].exp_d));
      end
    end

    // Burst across the top of the address space.
    d[0] = 8'h11; d[1] = 8'h22;
    wr_txn(8'hA0, 8'h0F, d, 2, 1'b1);
    check("wrap_mem15", 32'(mem[15]), 32'h11);
    check("wrap_mem0", 32'(mem[0]), 32'h22);

    // Combined read of 0xC3, 0x3C.
    d[0] = 8'hC3; d[1] = 8'h3C;
    wr_txn(8'hA0, 8'h07, d, 2, 1'b1);
    rd_txn(8'h07, 2);

    // STOP after four data bits.
    base = st_a.size();
    bus_start();
    write_byte(8'hA0, a); check("abort_dev_ack", 32'(a), 32'd1);
    write_byte(8'h05, a); check("abort_addr_ack", 32'(a), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    check("abort_no_strobe", 32'(st_a.size() - base), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // Reset while the slave is driving bit 7 (0) of 0x3C.
    bus_start();
    write_byte(8'hA0, a); check("rstrd_dev_ack", 32'(a), 32'd1);
    write_byte(8'h08, a); check("rstrd_addr_ack", 32'(a), 32'd1);
    bus_start();
    write_byte(8'hA1, a); check("rstrd_rd_ack", 32'(a), 32'd1);
    tick(2);
    check("rstrd_oe_driving", 32'(sda_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstrd_oe", 32'(sda_oe), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    check("rstrd_addr", 32'(mem_addr_in), 32'd0);
    check("rstrd_state", 32'(dut.state_q), 32'(S_IDLE));
    tick(3);
    reset_n = 1'b1;
    tick(2);
    bus_stop();
    check("rstrd_busy_after", 32'(busy), 32'd0);

    // Randomized traffic against the reference image.
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    wr_txn(8'hA0, 8'h00, d, 16, 1'b1);
    for (int it = 0; it < 10; it++) begin
      ra = 8'($urandom);
      n  = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) d[i] = 8'($urandom);
      wr_txn(8'hA0, ra, d, n, 1'b1);
      ra = 8'($urandom);
      n  = int'($urandom_range(1, 4));
      rd_txn(ra, n);
    end
    for (int i = 0; i < DEPTH; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
